// File: rtl/block1_pool_collector.sv
// block1_pool_collector
//   Collects 8-channel pooled pixels into a first-word-fall-through FIFO and
//   flags the end of each pooled frame once every buffered pixel has left.
//
// Ports
//   clk, resetn               : clock (rising edge), async active-low reset
//   valid_in, data_in_0..7    : pooled pixel in; no upstream backpressure,
//                               pixels arriving into a full FIFO are dropped
//   ready_in                  : downstream accepts the current head pixel
//   valid_out, data_out_0..7  : FIFO head (valid_out = FIFO not empty)
//   frame_done                : one-cycle pulse after a whole frame drained
//   overflow, level           : only with POOL_COLLECTOR_STATUS_EN defined;
//                               sticky drop flag and current occupancy
//
// Optional feature macro: POOL_COLLECTOR_STATUS_EN
module block1_pool_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  input  logic [DATA_WIDTH-1:0] data_in_4,
  input  logic [DATA_WIDTH-1:0] data_in_5,
  input  logic [DATA_WIDTH-1:0] data_in_6,
  input  logic [DATA_WIDTH-1:0] data_in_7,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic [DATA_WIDTH-1:0] data_out_3,
  output logic [DATA_WIDTH-1:0] data_out_4,
  output logic [DATA_WIDTH-1:0] data_out_5,
  output logic [DATA_WIDTH-1:0] data_out_6,
  output logic [DATA_WIDTH-1:0] data_out_7,
  output logic                  frame_done
`ifdef POOL_COLLECTOR_STATUS_EN
  ,
  output logic                  overflow,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW        = $clog2(DEPTH);
  localparam int CNTW      = AW + 1;
  localparam int FRAME_PIX = (WIDTH / 2) * (HEIGHT / 2);
  localparam int CW        = $clog2(FRAME_PIX + 1);
  localparam int EW        = 8 * DATA_WIDTH;

  localparam logic [CNTW-1:0] FULL_LVL = CNTW'(DEPTH);
  localparam logic [CW-1:0]   LAST_PIX = CW'(FRAME_PIX - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic [CW-1:0]   r_pix_cnt;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_last_pix;
  logic [EW-1:0]   w_din;
  logic [EW-1:0]   w_head;

  assign w_full  = (r_count == FULL_LVL);
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & ready_in;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign w_push  = valid_in & (~w_full | w_pop);

  // Every arriving pixel counts toward the frame, stored or dropped.
  assign w_last_pix = valid_in & (r_pix_cnt == LAST_PIX);

  assign w_din = {data_in_7, data_in_6, data_in_5, data_in_4,
                  data_in_3, data_in_2, data_in_1, data_in_0};

  // ---------------------------------------------------------------- storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_din;
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign valid_out  = ~w_empty;
  assign data_out_0 = w_head[0*DATA_WIDTH +: DATA_WIDTH];
  assign data_out_1 = w_head[1*DATA_WIDTH +: DATA_WIDTH];
  assign data_out_2 = w_head[2*DATA_WIDTH +: DATA_WIDTH];
  assign data_out_3 = w_head[3*DATA_WIDTH +: DATA_WIDTH];
  assign data_out_4 = w_head[4*DATA_WIDTH +: DATA_WIDTH];
  assign data_out_5 = w_head[5*DATA_WIDTH +: DATA_WIDTH];
  assign data_out_6 = w_head[6*DATA_WIDTH +: DATA_WIDTH];
  assign data_out_7 = w_head[7*DATA_WIDTH +: DATA_WIDTH];

  // ------------------------------------------------- pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------- input pixel counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pix_cnt <= '0;
    end else if (valid_in) begin
      if (r_pix_cnt == LAST_PIX) begin
        r_pix_cnt <= '0;
      end else begin
        r_pix_cnt <= r_pix_cnt + CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        // A single-pixel frame completes on its first pixel.
        if (valid_in) begin
          w_next = w_last_pix ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last_pix) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_empty) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    frame_done = 1'b0;
    if (r_state == ST_DONE) begin
      frame_done = 1'b1;
    end
  end

`ifdef POOL_COLLECTOR_STATUS_EN
  // ---------------------------------------------------------- status ports
  logic r_overflow;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
    end else if (valid_in & w_full & ~w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
  assign level    = r_count;
`endif

endmodule

// File: tb/tb_block1_pool_collector.sv
// tb_block1_pool_collector
//   Directed bench for block1_pool_collector with WIDTH=HEIGHT=4, DEPTH=4
//   (four pixels per frame). Channel k of pixel id p carries p*8+k.
module tb_block1_pool_collector;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          valid_in;
  logic          ready_in;
  logic          valid_out;
  logic          frame_done;
  logic [DW-1:0] din  [8];
  logic [DW-1:0] dout [8];
`ifdef POOL_COLLECTOR_STATUS_EN
  logic          overflow;
  logic [2:0]    level;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  block1_pool_collector #(
    .DATA_WIDTH(DW),
    .WIDTH     (4),
    .HEIGHT    (4),
    .DEPTH     (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid_in  (valid_in),
    .data_in_0 (din[0]),
    .data_in_1 (din[1]),
    .data_in_2 (din[2]),
    .data_in_3 (din[3]),
    .data_in_4 (din[4]),
    .data_in_5 (din[5]),
    .data_in_6 (din[6]),
    .data_in_7 (din[7]),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out_0(dout[0]),
    .data_out_1(dout[1]),
    .data_out_2(dout[2]),
    .data_out_3(dout[3]),
    .data_out_4(dout[4]),
    .data_out_5(dout[5]),
    .data_out_6(dout[6]),
    .data_out_7(dout[7]),
    .frame_done(frame_done)
`ifdef POOL_COLLECTOR_STATUS_EN
    ,
    .overflow  (overflow),
    .level     (level)
`endif
  );

  typedef struct {
    bit vin;
    int pix;
    bit rdy;
    bit evout;
    int epix;
    bit efd;
    int elvl;
    bit eovf;
  } vec_t;

  localparam int NVEC = 21;
  vec_t tbl [NVEC];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_head(input string name, input int id);
    for (int k = 0; k < 8; k++) begin
      check(name, longint'(dout[k]), longint'(id * 8 + k));
    end
  endtask

  task automatic set_pix(input int id);
    for (int k = 0; k < 8; k++) begin
      din[k] = DW'(id * 8 + k);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn   = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    @(negedge clk);
    resetn   = 1'b1;
  endtask

  // Waits at most max_cyc cycles for a frame_done pulse.
  task automatic wait_fd(input string name, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, longint'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected finish");
    $fatal(1);
  end

  initial begin
    int  next_exp;
    int  fd_cnt;
    int  sent;
    bit  prev_stall;
    logic [DW-1:0] prev0;
    logic [DW-1:0] prev7;

    //            vin pix rdy | vout pix fd lvl ovf
    tbl[0]  = '{1, 0,  1,   0, 0,  0, 0, 0};
    tbl[1]  = '{1, 1,  1,   1, 0,  0, 1, 0};
    tbl[2]  = '{1, 2,  1,   1, 1,  0, 1, 0};
    tbl[3]  = '{1, 3,  1,   1, 2,  0, 1, 0};
    tbl[4]  = '{0, 0,  1,   1, 3,  0, 1, 0};
    tbl[5]  = '{0, 0,  1,   0, 0,  0, 0, 0};
    tbl[6]  = '{0, 0,  1,   0, 0,  1, 0, 0};
    tbl[7]  = '{0, 0,  1,   0, 0,  0, 0, 0};
    tbl[8]  = '{1, 16, 0,   0, 0,  0, 0, 0};
    tbl[9]  = '{1, 17, 0,   1, 16, 0, 1, 0};
    tbl[10] = '{1, 18, 0,   1, 16, 0, 2, 0};
    tbl[11] = '{1, 19, 0,   1, 16, 0, 3, 0};
    tbl[12] = '{1, 20, 0,   1, 16, 0, 4, 0};
    tbl[13] = '{1, 21, 0,   1, 16, 0, 4, 1};
    tbl[14] = '{0, 0,  1,   1, 16, 0, 4, 1};
    tbl[15] = '{0, 0,  1,   1, 17, 0, 3, 1};
    tbl[16] = '{0, 0,  1,   1, 18, 0, 2, 1};
    tbl[17] = '{0, 0,  1,   1, 19, 0, 1, 1};
    tbl[18] = '{0, 0,  1,   0, 0,  0, 0, 1};
    tbl[19] = '{0, 0,  1,   0, 0,  1, 0, 1};
    tbl[20] = '{0, 0,  1,   0, 0,  0, 0, 1};

    // Reset state and idle behaviour
    resetn   = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    set_pix(0);
    #12;
    check("rst_valid_out", longint'(valid_out), 0);
    check("rst_frame_done", longint'(frame_done), 0);
`ifdef POOL_COLLECTOR_STATUS_EN
    check("rst_level", longint'(level), 0);
    check("rst_overflow", longint'(overflow), 0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_valid_out", longint'(valid_out), 0);
      check("idle_frame_done", longint'(frame_done), 0);
    end

    // Table: one frame at full rate, then a stalled frame with two drops
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      valid_in = tbl[i].vin;
      set_pix(tbl[i].pix);
      ready_in = tbl[i].rdy;
      check($sformatf("vec%0d_valid_out", i), longint'(valid_out), longint'(tbl[i].evout));
      if (tbl[i].evout) begin
        check_head($sformatf("vec%0d_head", i), tbl[i].epix);
      end
      check($sformatf("vec%0d_frame_done", i), longint'(frame_done), longint'(tbl[i].efd));
`ifdef POOL_COLLECTOR_STATUS_EN
      check($sformatf("vec%0d_level", i), longint'(level), longint'(tbl[i].elvl));
      check($sformatf("vec%0d_overflow", i), longint'(overflow), longint'(tbl[i].eovf));
`endif
    end

    // Full FIFO: write and pop on the same edge
    do_reset();
    for (int p = 32; p < 36; p++) begin
      @(negedge clk);
      valid_in = 1'b1;
      set_pix(p);
    end
    @(negedge clk);
    set_pix(36);
    ready_in = 1'b1;
    check_head("full_head_before", 32);
`ifdef POOL_COLLECTOR_STATUS_EN
    check("full_level_before", longint'(level), 4);
`endif
    @(negedge clk);
    valid_in = 1'b0;
    ready_in = 1'b0;
    check("full_valid_after", longint'(valid_out), 1);
    check_head("full_head_after", 33);
`ifdef POOL_COLLECTOR_STATUS_EN
    check("full_level_after", longint'(level), 4);
    check("full_overflow_after", longint'(overflow), 0);
`endif
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      ready_in = 1'b1;
      check("full_drain_valid", longint'(valid_out), 1);
      check_head("full_drain_head", 33 + j);
    end
    wait_fd("full_frame_done", 6);

    // Three frames with ready_in toggling every cycle
    do_reset();
    next_exp   = 64;
    fd_cnt     = 0;
    sent       = 0;
    prev_stall = 1'b0;
    prev0      = '0;
    prev7      = '0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      ready_in = (c % 2 == 0);
      if ((c % 4 == 0) && (sent < 12)) begin
        valid_in = 1'b1;
        set_pix(64 + sent);
        sent++;
      end else begin
        valid_in = 1'b0;
      end
      if (prev_stall) begin
        check("stall_valid", longint'(valid_out), 1);
        check("stall_ch0", longint'(dout[0]), longint'(prev0));
        check("stall_ch7", longint'(dout[7]), longint'(prev7));
      end
      if (valid_out && ready_in) begin
        check_head("toggle_order", next_exp);
        next_exp++;
      end
      if (frame_done) begin
        fd_cnt++;
      end
      prev_stall = valid_out && !ready_in;
      prev0      = dout[0];
      prev7      = dout[7];
    end
    check("toggle_delivered", longint'(next_exp), 76);
    check("toggle_frame_done_count", longint'(fd_cnt), 3);

    // Reset mid-frame discards data and restarts the pixel count
    do_reset();
    for (int p = 80; p < 82; p++) begin
      @(negedge clk);
      valid_in = 1'b1;
      set_pix(p);
    end
    @(negedge clk);
    valid_in = 1'b0;
    check("midrst_valid_before", longint'(valid_out), 1);
    resetn = 1'b0;
    #1;
    check("midrst_valid_out", longint'(valid_out), 0);
    check("midrst_frame_done", longint'(frame_done), 0);
`ifdef POOL_COLLECTOR_STATUS_EN
    check("midrst_level", longint'(level), 0);
`endif
    @(negedge clk);
    resetn   = 1'b1;
    ready_in = 1'b1;
    fd_cnt   = 0;
    for (int p = 90; p < 93; p++) begin
      @(negedge clk);
      valid_in = 1'b1;
      set_pix(p);
      if (p == 91) begin
        check_head("midrst_fresh_head", 90);
      end
      if (frame_done) fd_cnt++;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (frame_done) fd_cnt++;
    end
    check("midrst_no_early_done", longint'(fd_cnt), 0);
    @(negedge clk);
    valid_in = 1'b1;
    set_pix(93);
    @(negedge clk);
    valid_in = 1'b0;
    check_head("midrst_last_head", 93);
    wait_fd("midrst_frame_done", 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
